// File: rtl/arb_pkg.sv
// Shared sizes, state type and default hold limit for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ       = 8;
  localparam int unsigned ID_W          = 3;
  localparam int unsigned MAX_HOLD_DFLT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked request at or above i_ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_cand;
  logic [ID_W-1:0]    w_pos;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;

  always_comb begin
    w_cand  = i_req & ~i_mask;
    w_pos   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // ID_W-bit addition wraps 7 -> 0 for free
      w_pos = i_ptr + ID_W'(k);
      if (!w_found && w_cand[w_pos]) begin
        w_found = 1'b1;
        w_idx   = w_pos;
      end
    end
  end

  always_comb begin
    o_pick = '0;
    if (w_found) o_pick[w_idx] = 1'b1;
    o_idx = w_idx;
    o_any = w_found;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot grant.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD busy cycles.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               Release,
  output logic [NUM_REQ-1:0] Grant,
  output logic [ID_W-1:0]    Out,
  output logic               Valid,
  output logic               Timeout
);

  state_e             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [ID_W-1:0]    r_out, w_out_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic               w_rel_norm, w_forced, w_release_ev;
  logic [NUM_REQ-1:0] w_pick_mask, w_pick;
  logic [ID_W-1:0]    w_pick_ptr, w_pick_idx;
  logic               w_pick_any;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
  end

  // In BUSY the search starts just past the holder and skips it
  assign w_pick_mask = (r_state == BUSY) ? r_grant : '0;
  assign w_pick_ptr  = (r_state == BUSY) ? r_out + ID_W'(1) : r_ptr;

  rr_pick u_pick (
    .i_req  (Req),
    .i_mask (w_pick_mask),
    .i_ptr  (w_pick_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_rel_norm   = Release || !Req[r_out];
  assign w_release_ev = (r_state == BUSY) && (w_rel_norm || w_forced);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold;

  assign w_forced = (r_state == BUSY) && !w_rel_norm && (r_hold == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_pick_any && (r_state == IDLE || w_release_ev)) begin
      r_hold <= '0;
    end else if (r_state == BUSY && !w_release_ev) begin
      r_hold <= r_hold + 8'd1;
    end
  end
`else
  assign w_forced = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = BUSY;
      BUSY:    if (w_release_ev && !w_pick_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_out_nxt     = r_out;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = w_forced;
    if (w_release_ev) w_ptr_nxt = r_out + ID_W'(1);
    if (r_state == IDLE || w_release_ev) begin
      w_grant_nxt = w_pick;
      w_out_nxt   = w_pick_idx;
      w_valid_nxt = w_pick_any;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_grant   <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_out     <= w_out_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign Grant   = r_grant;
  assign Out     = r_out;
  assign Valid   = r_valid;
  assign Timeout = r_timeout;

endmodule
